// File: rtl/i281_exec_ctrl.sv
// Execution sequencer for the i281 single-cycle CPU.
// Produces the CPU run enable and supports free-run, single-step,
// PC breakpoint and self-loop halt. Counts committed instructions.
module i281_exec_ctrl #(
  parameter int PC_W              = 6,
  parameter int CNT_W             = 16,
  parameter bit HALT_ON_SELF_LOOP = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run_btn,
  input  logic             step_btn,
  input  logic             stop_btn,
  input  logic             bp_enable,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  current_pc,
  input  logic [PC_W-1:0]  next_pc,
  input  logic             pc_we,
  output logic             run,
  output logic [2:0]       state,
  output logic             bp_hit,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_BREAK = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic             run_btn_q, step_btn_q, stop_btn_q;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;

  logic run_edge, step_edge, stop_edge;
  logic commit, self_loop, bp_match;

  // Button rising-edge detection and per-cycle event decode
  always_comb begin
    run_edge  = run_btn  & ~run_btn_q;
    step_edge = step_btn & ~step_btn_q;
    stop_edge = stop_btn & ~stop_btn_q;
    commit    = (state_q == ST_RUN) || (state_q == ST_STEP);
    self_loop = commit & pc_we & (next_pc == current_pc) & HALT_ON_SELF_LOOP;
    bp_match  = commit & bp_enable & (next_pc == bp_addr);
  end

  // Next-state selection; earlier tests in each branch take priority
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_BREAK: begin
        if (stop_edge)      state_d = ST_IDLE;
        else if (run_edge)  state_d = ST_RUN;
        else if (step_edge) state_d = ST_STEP;
      end
      ST_RUN: begin
        if (stop_edge)      state_d = ST_IDLE;
        else if (self_loop) state_d = ST_HALT;
        else if (bp_match)  state_d = ST_BREAK;
      end
      ST_STEP: begin
        // A single step never traps on the breakpoint; it only halts on a self-loop.
        if (self_loop && !stop_edge) state_d = ST_HALT;
        else                         state_d = ST_IDLE;
      end
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Saturating count of committed instructions
  always_comb begin
    instr_count_d = instr_count_q;
    if (commit && (instr_count_q != CNT_MAX)) instr_count_d = instr_count_q + 1'b1;
  end

  // State, counter and button-history registers; history loads 1 so a
  // button held through reset does not register as a press
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      instr_count_q <= '0;
      run_btn_q     <= 1'b1;
      step_btn_q    <= 1'b1;
      stop_btn_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
      run_btn_q     <= run_btn;
      step_btn_q    <= step_btn;
      stop_btn_q    <= stop_btn;
    end
  end

  // Outputs decode the registered state only
  always_comb begin
    state       = state_q;
    run         = (state_q == ST_RUN) || (state_q == ST_STEP);
    bp_hit      = (state_q == ST_BREAK);
    halted      = (state_q == ST_HALT);
    instr_count = instr_count_q;
  end

endmodule

// File: tb/tb_i281_exec_ctrl.sv
// Randomized and directed bench for i281_exec_ctrl with a behavioural model.
module tb_i281_exec_ctrl;

  localparam int PC_W = 6;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            run_btn = 1'b0, step_btn = 1'b0, stop_btn = 1'b0;
  logic            bp_enable = 1'b0;
  logic [PC_W-1:0] bp_addr = '0, current_pc = '0, next_pc = '0;
  logic            pc_we = 1'b0;

  logic            run, bp_hit, halted;
  logic [2:0]      state;
  logic [15:0]     instr_count;
  logic            run4, bp_hit4, halted4;
  logic [2:0]      state4;
  logic [3:0]      instr_count4;

  i281_exec_ctrl #(.PC_W(PC_W), .CNT_W(16), .HALT_ON_SELF_LOOP(1'b1)) dut (
    .clock(clock), .reset(reset), .run_btn(run_btn), .step_btn(step_btn),
    .stop_btn(stop_btn), .bp_enable(bp_enable), .bp_addr(bp_addr),
    .current_pc(current_pc), .next_pc(next_pc), .pc_we(pc_we),
    .run(run), .state(state), .bp_hit(bp_hit), .halted(halted),
    .instr_count(instr_count)
  );

  // Narrow-counter instance sharing all inputs, used to observe saturation
  i281_exec_ctrl #(.PC_W(PC_W), .CNT_W(4), .HALT_ON_SELF_LOOP(1'b1)) dut4 (
    .clock(clock), .reset(reset), .run_btn(run_btn), .step_btn(step_btn),
    .stop_btn(stop_btn), .bp_enable(bp_enable), .bp_addr(bp_addr),
    .current_pc(current_pc), .next_pc(next_pc), .pc_we(pc_we),
    .run(run4), .state(state4), .bp_hit(bp_hit4), .halted(halted4),
    .instr_count(instr_count4)
  );

  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_miss = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model: mode numbers are the visible state codes
  // (0 idle, 1 free-run, 2 single step, 3 breakpoint, 4 halted).
  int m_mode = 0;
  int m_cnt  = 0;
  int m_cnt4 = 0;
  bit p_run = 1, p_step = 1, p_stop = 1;

  always @(posedge clock) begin
    bit executing, re, se, pe, loop_hit, bp_hit_now;
    if (reset) begin
      m_mode = 0; m_cnt = 0; m_cnt4 = 0;
      p_run = 1; p_step = 1; p_stop = 1;
    end else begin
      re = run_btn && !p_run;
      se = step_btn && !p_step;
      pe = stop_btn && !p_stop;
      executing  = (m_mode == 1) || (m_mode == 2);
      loop_hit   = executing && pc_we && (next_pc == current_pc);
      bp_hit_now = executing && bp_enable && (next_pc == bp_addr);
      if (executing) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      if (m_mode == 0 || m_mode == 3) begin
        if (pe) m_mode = 0;
        else if (re) m_mode = 1;
        else if (se) m_mode = 2;
      end else if (m_mode == 1) begin
        if (pe) m_mode = 0;
        else if (loop_hit) m_mode = 4;
        else if (bp_hit_now) m_mode = 3;
      end else if (m_mode == 2) begin
        m_mode = (loop_hit && !pe) ? 4 : 0;
      end
      p_run = run_btn; p_step = step_btn; p_stop = stop_btn;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clock) begin
    if (cmp_en) begin
      chk("state", int'(state), m_mode);
      chk("run", int'(run), int'((m_mode == 1) || (m_mode == 2)));
      chk("bp_hit", int'(bp_hit), int'(m_mode == 3));
      chk("halted", int'(halted), int'(m_mode == 4));
      chk("instr_count", int'(instr_count), m_cnt);
      chk("instr_count4", int'(instr_count4), m_cnt4);
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1; tick();
    reset = 1'b0; tick();
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    cmp_en = 1'b1;
    tick();
    chk("lit_reset_state", int'(state), 0);
    chk("lit_reset_count", int'(instr_count), 0);

    // Single step
    step_btn = 1; pc_we = 1; current_pc = 5; next_pc = 6;
    tick();
    chk("lit_step_run", int'(run), 1);
    step_btn = 0;
    tick();
    chk("lit_step_done_run", int'(run), 0);
    chk("lit_step_done_state", int'(state), 0);
    chk("lit_step_count", int'(instr_count), 1);

    // Free-run into breakpoint at 4
    do_reset();
    bp_enable = 1; bp_addr = 4; pc_we = 1; current_pc = 0; next_pc = 1; run_btn = 1;
    tick();
    chk("lit_run_start", int'(run), 1);
    run_btn = 0;
    for (int k = 1; k <= 4; k++) begin
      current_pc = PC_W'(k - 1); next_pc = PC_W'(k);
      tick();
    end
    chk("lit_bp_state", int'(state), 3);
    chk("lit_bp_hit", int'(bp_hit), 1);
    chk("lit_bp_run", int'(run), 0);
    chk("lit_bp_count", int'(instr_count), 4);

    // Resume from breakpoint: no re-trap
    run_btn = 1; current_pc = 4; next_pc = 5;
    tick();
    chk("lit_resume_run", int'(run), 1);
    run_btn = 0;
    tick();
    chk("lit_resume_state", int'(state), 1);
    chk("lit_resume_count", int'(instr_count), 5);

    // Self-loop halt; buttons ignored; reset exits
    current_pc = 12; next_pc = 12;
    tick();
    chk("lit_halt_state", int'(state), 4);
    chk("lit_halt_flag", int'(halted), 1);
    chk("lit_halt_run", int'(run), 0);
    run_btn = 1; step_btn = 1; tick();
    run_btn = 0; step_btn = 0; tick();
    run_btn = 1; tick();
    chk("lit_halt_sticky", int'(state), 4);
    run_btn = 0;
    do_reset();
    chk("lit_halt_reset_state", int'(state), 0);
    chk("lit_halt_reset_count", int'(instr_count), 0);

    // Simultaneous run/step edges, then stop beating a breakpoint match
    run_btn = 1; step_btn = 1;
    tick();
    chk("lit_run_wins", int'(state), 1);
    run_btn = 0; step_btn = 0;
    pc_we = 0; bp_enable = 1; bp_addr = 9; current_pc = 8; next_pc = 9; stop_btn = 1;
    tick();
    chk("lit_stop_wins_state", int'(state), 0);
    chk("lit_stop_wins_bp", int'(bp_hit), 0);
    stop_btn = 0;

    // Button held through reset makes no edge; narrow counter saturates
    run_btn = 1; reset = 1; tick(); tick();
    reset = 0; tick(); tick();
    chk("lit_held_no_edge", int'(state), 0);
    run_btn = 0; tick();
    run_btn = 1; tick();
    chk("lit_held_release_run", int'(state), 1);
    run_btn = 0; bp_enable = 0;
    repeat (20) tick();
    chk("lit_sat_count4", int'(instr_count4), 15);
    chk("lit_count16", int'(instr_count), 20);

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 3) == 0) run_btn  = ~run_btn;
      if ($urandom_range(0, 3) == 0) step_btn = ~step_btn;
      if ($urandom_range(0, 9) == 0) stop_btn = ~stop_btn;
      bp_enable  = $urandom_range(0, 1) == 1;
      bp_addr    = PC_W'($urandom_range(0, 15));
      current_pc = PC_W'($urandom_range(0, 15));
      next_pc    = PC_W'($urandom_range(0, 15));
      pc_we      = $urandom_range(0, 3) != 0;
      tick();
    end

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/i281_exec_ctrl.md
Name: i281_exec_ctrl

Overview:
Execution sequencer for the i281 single-cycle CPU. It generates the `run` enable that gates the PC, register file, flags and data memory, and supports free-run, single-step, PC breakpoint and self-loop halt detection. It observes the PC datapath (`current_pc`, `next_pc`, PC write enable) and counts executed instructions. It sits at top level between the board buttons/switches and the CPU `run` input.

Parameters:
PC_W, 6, width of program counter / breakpoint address
CNT_W, 16, width of executed-instruction counter
HALT_ON_SELF_LOOP, 1, 1 = enter HALT when an executed instruction writes PC to its own address

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
run_btn  in  1  level input; rising edge requests free-run
step_btn  in  1  level input; rising edge requests one instruction
stop_btn  in  1  level input; rising edge requests stop to IDLE
bp_enable  in  1  breakpoint compare enable
bp_addr  in  PC_W  breakpoint PC value
current_pc  in  PC_W  PC register output
next_pc  in  PC_W  PC update output
pc_we  in  1  PC write enable from control logic (ctrl bit 3)
run  out  1  CPU execute enable; exactly one instruction commits per cycle with run=1
state  out  3  IDLE=0, RUN=1, STEP=2, BREAK=3, HALT=4
bp_hit  out  1  high while in BREAK
halted  out  1  high while in HALT
instr_count  out  CNT_W  number of cycles with run=1 since reset

Behaviour:
- Reset (sampled at clock edge): state=IDLE, run=0, bp_hit=0, halted=0, instr_count=0. Button history registers load 1, so a button held through reset produces no edge.
- Edge detect: `X_edge = X_btn & ~X_btn_q`, with `X_btn_q` registered each cycle. Inputs are already synchronous; no debouncing in this block.
- All outputs are decoded from the registered state only; no combinational input-to-output path.
  - run = (state==RUN) | (state==STEP)
  - bp_hit = (state==BREAK)
  - halted = (state==HALT)
- Latency: a button edge sampled at edge n changes state at edge n; the new run value is valid in cycle n+1.
- `commit = run`
- `self_loop = commit & pc_we & (next_pc==current_pc) & HALT_ON_SELF_LOOP`
- `bp_match = commit & bp_enable & (next_pc==bp_addr)`
- Transitions (priority listed first to last):
  - IDLE: stop_edge -> IDLE; run_edge -> RUN; step_edge -> STEP; else hold.
  - RUN: stop_edge -> IDLE; self_loop -> HALT; bp_match -> BREAK; else RUN. The instruction in the current cycle always commits. Breakpoint semantics: the CPU stops with PC = bp_addr, before that instruction executes.
  - STEP: lasts exactly 1 cycle. self_loop -> HALT; else IDLE. A bp_match in STEP is ignored. A stop_edge in STEP -> IDLE.
  - BREAK: stop_edge -> IDLE; run_edge -> RUN; step_edge -> STEP; else hold. Resuming executes the instruction at bp_addr. The compare uses next_pc, so resume is not re-trapped unless the code branches back to bp_addr.
  - HALT: exits only on reset; all buttons are ignored.
- Simultaneous run_edge and step_edge: run wins.
- instr_count: increments by 1 on each clock edge with run=1 and saturates at 2^CNT_W-1 (no wrap).
- Reset mid-RUN: the next cycle has run=0. The CPU's own reset is driven separately; this block does not reset the PC.
- bp_addr and bp_enable may change at any time; they are used combinationally in the cycle they are sampled.

Test Plan:
- Reset, then step_btn pulse 0->1->0 with pc_we=1, current_pc=5, next_pc=6 -> run high for exactly 1 cycle, state returns to 0, instr_count=1.
- run_btn pulse, next_pc sequence 1,2,3,4, bp_enable=1, bp_addr=4 -> state=3 and bp_hit=1 on the edge where next_pc=4; instr_count=4; run low afterwards.
- From BREAK, pulse run_btn -> run high in the next cycle, one instruction commits with current_pc=4, then free-run continues; no immediate re-trap.
- RUN with pc_we=1, current_pc=next_pc=12 -> state=4, halted=1, run=0. run_btn and step_btn pulses have no effect; reset returns state=0 and instr_count=0.
- IDLE with run_btn and step_btn rising in the same cycle -> state=1. In RUN, stop_btn edge and bp_match in the same cycle -> state=0, bp_hit=0.
- Hold run_btn=1 through reset, release reset -> no transition until run_btn goes 0 then 1. With CNT_W=4, free-run for 20 cycles -> instr_count=15.
